// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and defaults for the system clock divider controller.
package clk_div_ctrl_pkg;

  localparam int DIV_W       = 9;
  localparam int DEFAULT_DIV = 4;
  localparam int IDX_W       = 3;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ARB,
    WAIT_EDGE,
    HOLD,
    SETTLE,
    ACK,
    NACK
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after ptr.
module rr_arbiter
  import clk_div_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Scan offsets from the pointer; the inner loop keeps every bit select constant.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_valid && req[j] && (j == ((int'(ptr) + off) % NUM_REQ))) begin
          grant[j]    = 1'b1;
          grant_idx   = IDX_W'(j);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Owns the system clock divide value and sequences requester-driven changes
// so the divider is only reprogrammed right after a sys_clk rising edge.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int DIV_W       = clk_div_ctrl_pkg::DIV_W,
  parameter int DEFAULT_DIV = clk_div_ctrl_pkg::DEFAULT_DIV,
  parameter int HOLD_CYC    = 2,
  parameter int SETTLE_TOG  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DIV_W-1:0] req_div,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       nack,
  input  logic                     sys_clk_in,
  output logic [DIV_W-1:0]         clk_divider,
  output logic                     div_reset_n,
  output logic                     busy,
  output logic [2:0]               owner
);

  localparam int HC_W = $clog2(HOLD_CYC + 1);
  localparam int SC_W = $clog2(SETTLE_TOG + 1);
  localparam logic [HC_W-1:0] HOLD_LAST   = HC_W'(HOLD_CYC - 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_TOG - 1);

  state_t             state;
  state_t             state_nxt;
  logic               sys_clk_d;
  logic               rise;
  logic               tog;
  logic [IDX_W-1:0]   rr_ptr;
  logic [DIV_W-1:0]   new_div;
  logic [DIV_W-1:0]   sel_div;
  logic [HC_W-1:0]    hold_cnt;
  logic [SC_W-1:0]    settle_cnt;
  logic [9:0]         wd_cnt;
  logic               wd_sat;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign rise   = sys_clk_in & ~sys_clk_d;
  assign tog    = sys_clk_in ^ sys_clk_d;
  // A missing sys_clk edge must not stall the change forever.
  assign wd_sat = (int'(wd_cnt) >= 2 * int'(clk_divider) + 2) || (&wd_cnt);

  always_comb begin
    sel_div = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) sel_div = req_div[j*DIV_W +: DIV_W];
    end
  end

  always_comb begin
    state_nxt = state;
    ack       = '0;
    nack      = '0;
    busy      = (state != IDLE);
    case (state)
      INIT:      if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      IDLE:      if (|req) state_nxt = ARB;
      ARB: begin
        if (!grant_valid)              state_nxt = IDLE;
        else if (sel_div == '0)        state_nxt = NACK;
        else if (sel_div == clk_divider) state_nxt = ACK;
        else                           state_nxt = WAIT_EDGE;
      end
      WAIT_EDGE: if (rise || wd_sat) state_nxt = HOLD;
      HOLD:      if (hold_cnt == HOLD_LAST) state_nxt = SETTLE;
      SETTLE:    if (tog && (settle_cnt == SETTLE_LAST)) state_nxt = ACK;
      ACK:       state_nxt = IDLE;
      NACK:      state_nxt = IDLE;
      default:   state_nxt = INIT;
    endcase
    for (int k = 0; k < NUM_REQ; k++) begin
      ack[k]  = (state == ACK)  && (int'(owner) == k);
      nack[k] = (state == NACK) && (int'(owner) == k);
    end
  end

  // The new divide value lands in the same cycle the divider is put into reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      clk_divider <= DIV_W'(DEFAULT_DIV);
      div_reset_n <= 1'b0;
      owner       <= '0;
      rr_ptr      <= '0;
      new_div     <= '0;
      hold_cnt    <= '0;
      settle_cnt  <= '0;
      wd_cnt      <= '0;
      sys_clk_d   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sys_clk_d <= sys_clk_in;
      case (state)
        INIT: begin
          if (hold_cnt == HOLD_LAST) begin
            div_reset_n <= 1'b1;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ARB: begin
          wd_cnt <= '0;
          if (grant_valid) begin
            owner   <= grant_idx;
            new_div <= sel_div;
            rr_ptr  <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          end
        end
        WAIT_EDGE: begin
          if (rise || wd_sat) begin
            div_reset_n <= 1'b0;
            clk_divider <= new_div;
            hold_cnt    <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            div_reset_n <= 1'b1;
            hold_cnt    <= '0;
            settle_cnt  <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SETTLE: if (tog) settle_cnt <= settle_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl with a behavioural divider closing the sys_clk loop.
module tb_clk_div_ctrl;

  localparam int NUM_REQ = 3;
  localparam int DIV_W   = 9;
  localparam int HOLD    = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*DIV_W-1:0] req_div;
  logic [NUM_REQ-1:0]       ack;
  logic [NUM_REQ-1:0]       nack;
  logic                     sys_clk_in = 1'b0;
  logic [DIV_W-1:0]         clk_divider;
  logic                     div_reset_n;
  logic                     busy;
  logic [2:0]               owner;

  typedef struct {
    logic             is_ack;
    int               idx;
    logic [DIV_W-1:0] div;
    int               issue;
    int               lat;
  } exp_t;

  exp_t sb_q[$];
  int   per_q[$];
  int   cyc = 0;
  int   issue_cyc = 0;
  int   stim_timeouts = 0;
  int   checks = 0;
  int   failures = 0;
  logic done = 1'b0;
  int   dcnt = 0;

  clk_div_ctrl #(
    .NUM_REQ     (NUM_REQ),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (4),
    .HOLD_CYC    (HOLD),
    .SETTLE_TOG  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_div     (req_div),
    .ack         (ack),
    .nack        (nack),
    .sys_clk_in  (sys_clk_in),
    .clk_divider (clk_divider),
    .div_reset_n (div_reset_n),
    .busy        (busy),
    .owner       (owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: sys_clk toggles every clk_divider cycles while out of reset.
  always @(posedge clk) begin
    if (div_reset_n !== 1'b1) begin
      dcnt       <= 0;
      sys_clk_in <= 1'b0;
    end else if (dcnt + 1 >= int'(clk_divider)) begin
      dcnt       <= 0;
      sys_clk_in <= ~sys_clk_in;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ*DIV_W-1:0] divs);
    @(posedge clk);
    #1;
    req_div   = divs;
    req       = req | mask;
    issue_cyc = cyc;
  endtask

  task automatic pushExp(input logic is_ack, input int idx, input logic [DIV_W-1:0] div, input int lat);
    exp_t e;
    e.is_ack = is_ack;
    e.idx    = idx;
    e.div    = div;
    e.issue  = issue_cyc;
    e.lat    = lat;
    sb_q.push_back(e);
  endtask

  task automatic waitResponse(input int budget);
    logic [NUM_REQ-1:0] got;
    got = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((ack | nack) != '0) begin
        got = ack | nack;
        break;
      end
    end
    if (got == '0) begin
      stim_timeouts++;
      $display("[TB] timeout waiting for ack/nack at cycle %0d", cyc);
    end else begin
      @(posedge clk);
      #1;
      req = req & ~got;
    end
  endtask

  task automatic waitIdle(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      stim_timeouts++;
      $display("[TB] timeout waiting for idle at cycle %0d", cyc);
    end
  endtask

  task automatic waitDivReset(input logic level, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (div_reset_n === level) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      stim_timeouts++;
      $display("[TB] timeout waiting for div_reset_n=%0b at cycle %0d", level, cyc);
    end
  endtask

  task automatic waitPeriodDone(input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (per_q.size() == 0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      stim_timeouts++;
      $display("[TB] timeout waiting for period measurement at cycle %0d", cyc);
    end
  endtask

  // Stimulus: requesters raise req, push the expected response, and drop req after it.
  initial begin
    reset   = 1'b1;
    req     = '0;
    req_div = '0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    waitIdle(20);

    $display("[TB] change divider 4 -> 10 via requester 0");
    applyStimulus(3'b001, {9'd0, 9'd0, 9'd10});
    pushExp(1'b1, 0, 9'd10, 0);
    waitResponse(300);
    per_q.push_back(20);
    waitIdle(20);

    $display("[TB] same-value request from requester 1");
    applyStimulus(3'b010, {9'd0, 9'd10, 9'd0});
    pushExp(1'b1, 1, 9'd10, 2);
    waitResponse(20);
    waitIdle(20);

    $display("[TB] zero-value request from requester 2");
    applyStimulus(3'b100, {9'd0, 9'd10, 9'd0});
    pushExp(1'b0, 2, 9'd10, 2);
    waitResponse(20);
    waitPeriodDone(100);
    waitIdle(20);

    $display("[TB] simultaneous requests, pointer at 0");
    applyStimulus(3'b111, {9'd12, 9'd8, 9'd6});
    pushExp(1'b1, 0, 9'd6, 0);
    pushExp(1'b1, 1, 9'd8, 0);
    pushExp(1'b1, 2, 9'd12, 0);
    repeat (3) waitResponse(400);
    waitIdle(20);

    applyStimulus(3'b001, {9'd0, 9'd0, 9'd12});
    pushExp(1'b1, 0, 9'd12, 2);
    waitResponse(20);
    waitIdle(20);

    $display("[TB] simultaneous requests, pointer at 1");
    applyStimulus(3'b111, {9'd9, 9'd7, 9'd5});
    pushExp(1'b1, 1, 9'd7, 0);
    pushExp(1'b1, 2, 9'd9, 0);
    pushExp(1'b1, 0, 9'd5, 0);
    repeat (3) waitResponse(400);
    waitIdle(20);

    $display("[TB] reset during settle");
    applyStimulus(3'b001, {9'd0, 9'd0, 9'd6});
    waitDivReset(1'b0, 100);
    waitDivReset(1'b1, 10);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    issue_cyc = cyc;
    pushExp(1'b1, 0, 9'd6, 0);
    waitResponse(300);

    repeat (5) @(posedge clk);
    done = 1'b1;
  end

  // Monitor: all comparisons happen here, sampled on the falling clock edge.
  initial begin
    logic             s1;
    logic             s2;
    logic             rst_prev;
    logic [DIV_W-1:0] cd_prev;
    int               run;
    int               arm;
    int               last_rise;
    exp_t             e;
    logic [NUM_REQ-1:0] exp_ack;
    logic [NUM_REQ-1:0] exp_nack;
    s1 = 1'b0;
    s2 = 1'b0;
    rst_prev = 1'b0;
    cd_prev = '0;
    run = 0;
    arm = 0;
    last_rise = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);

      if (rst_prev)
        checkOutput("reset_values",
                    32'({clk_divider, div_reset_n, ack, nack, busy, owner}),
                    32'({9'd4, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000}));

      if (!reset && !rst_prev && (clk_divider !== cd_prev))
        checkOutput("div_change_at_rise", 32'({s2, s1, div_reset_n}), 32'({1'b0, 1'b1, 1'b0}));

      if (reset) begin
        run = 0;
      end else if (div_reset_n === 1'b0) begin
        run++;
      end else if (run != 0) begin
        checkOutput("div_reset_width", 32'(run), 32'(HOLD));
        run = 0;
      end

      if (arm == 0 && per_q.size() > 0) arm = 1;
      if (sys_clk_in && !s1) begin
        if (arm == 1) begin
          last_rise = cyc;
          arm = 2;
        end else if (arm == 2) begin
          checkOutput("sys_clk_period", 32'(cyc - last_rise), 32'(per_q.pop_front()));
          arm = 0;
        end
      end

      if ((ack | nack) != '0) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_resp", 32'({ack, nack}), 32'(0));
        end else begin
          e = sb_q.pop_front();
          exp_ack  = e.is_ack ? (3'b001 << e.idx) : 3'b000;
          exp_nack = e.is_ack ? 3'b000 : (3'b001 << e.idx);
          checkOutput("resp_ack_nack", 32'({ack, nack}), 32'({exp_ack, exp_nack}));
          checkOutput("resp_divider", 32'(clk_divider), 32'(e.div));
          if (e.lat > 0) checkOutput("resp_latency", 32'(cyc - e.issue), 32'(e.lat));
        end
      end

      s2 = s1;
      s1 = sys_clk_in;
      rst_prev = reset;
      cd_prev = clk_divider;
    end

    checkOutput("run_completed", 32'(done), 32'(1));
    checkOutput("pending_resp", 32'(sb_q.size()), 32'(0));
    checkOutput("pending_period", 32'(per_q.size()), 32'(0));
    checkOutput("wait_bounds", 32'(stim_timeouts), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
